// File: rtl/regfile_2w2r_sb.sv
// Dual-write, dual-read integer register file with an integrated busy-bit scoreboard.
// Write port 1 outranks port 0; reads and busy lookups are combinational.
module regfile_2w2r_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr0_en,
  input  logic [ADDR_W-1:0]   wr0_addr,
  input  logic [DATA_W-1:0]   wr0_data,
  input  logic                wr1_en,
  input  logic [ADDR_W-1:0]   wr1_addr,
  input  logic [DATA_W-1:0]   wr1_data,
  input  logic [ADDR_W-1:0]   rd_a_addr,
  output logic [DATA_W-1:0]   rd_a_data,
  output logic                rd_a_busy,
  input  logic [ADDR_W-1:0]   rd_b_addr,
  output logic [DATA_W-1:0]   rd_b_data,
  output logic                rd_b_busy,
  input  logic                sb_set_en,
  input  logic [ADDR_W-1:0]   sb_set_addr,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_next_s;
  logic                wr0_ok_s;
  logic                wr1_ok_s;
  logic                set_ok_s;

  // Qualify write/set requests; register 0 swallows them when hardwired.
  always_comb begin
    wr0_ok_s = wr0_en;
    wr1_ok_s = wr1_en;
    set_ok_s = sb_set_en;
    if (ZERO_REG != 0) begin
      wr0_ok_s = wr0_en    && (wr0_addr    != {ADDR_W{1'b0}});
      wr1_ok_s = wr1_en    && (wr1_addr    != {ADDR_W{1'b0}});
      set_ok_s = sb_set_en && (sb_set_addr != {ADDR_W{1'b0}});
    end else begin
      wr0_ok_s = wr0_en;
      wr1_ok_s = wr1_en;
      set_ok_s = sb_set_en;
    end
  end

  // Register storage; port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (wr0_ok_s) begin
        regs_r[wr0_addr] <= wr0_data;
      end
      if (wr1_ok_s) begin
        regs_r[wr1_addr] <= wr1_data;
      end
    end
  end

  // Scoreboard next state: writeback clears, issue sets, set applied last so it wins.
  always_comb begin
    busy_next_s = busy_r;
    if (wr0_ok_s) begin
      busy_next_s[wr0_addr] = 1'b0;
    end else begin
      busy_next_s = busy_next_s;
    end
    if (wr1_ok_s) begin
      busy_next_s[wr1_addr] = 1'b0;
    end else begin
      busy_next_s = busy_next_s;
    end
    if (set_ok_s) begin
      busy_next_s[sb_set_addr] = 1'b1;
    end else begin
      busy_next_s = busy_next_s;
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  assign busy_vec = busy_r;

  // Read port A: forward same-cycle write data, and mask busy when forwarded
  // unless a newer producer is being issued to the same register this cycle.
  always_comb begin
    rd_a_data = regs_r[rd_a_addr];
    rd_a_busy = busy_r[rd_a_addr];
    if (BYPASS != 0 && wr1_ok_s && wr1_addr == rd_a_addr) begin
      rd_a_data = wr1_data;
      rd_a_busy = set_ok_s && (sb_set_addr == rd_a_addr);
    end else if (BYPASS != 0 && wr0_ok_s && wr0_addr == rd_a_addr) begin
      rd_a_data = wr0_data;
      rd_a_busy = set_ok_s && (sb_set_addr == rd_a_addr);
    end else begin
      rd_a_data = regs_r[rd_a_addr];
      rd_a_busy = busy_r[rd_a_addr];
    end
    if (!reset || (ZERO_REG != 0 && rd_a_addr == {ADDR_W{1'b0}})) begin
      rd_a_data = {DATA_W{1'b0}};
      rd_a_busy = 1'b0;
    end else begin
      rd_a_data = rd_a_data;
    end
  end

  // Read port B: identical to port A.
  always_comb begin
    rd_b_data = regs_r[rd_b_addr];
    rd_b_busy = busy_r[rd_b_addr];
    if (BYPASS != 0 && wr1_ok_s && wr1_addr == rd_b_addr) begin
      rd_b_data = wr1_data;
      rd_b_busy = set_ok_s && (sb_set_addr == rd_b_addr);
    end else if (BYPASS != 0 && wr0_ok_s && wr0_addr == rd_b_addr) begin
      rd_b_data = wr0_data;
      rd_b_busy = set_ok_s && (sb_set_addr == rd_b_addr);
    end else begin
      rd_b_data = regs_r[rd_b_addr];
      rd_b_busy = busy_r[rd_b_addr];
    end
    if (!reset || (ZERO_REG != 0 && rd_b_addr == {ADDR_W{1'b0}})) begin
      rd_b_data = {DATA_W{1'b0}};
      rd_b_busy = 1'b0;
    end else begin
      rd_b_data = rd_b_data;
    end
  end

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Directed bench: one bypassing/zero-reg instance and one plain instance
// share the same stimulus and are checked against hand-computed values.
module tb_regfile_2w2r_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr0_en, wr1_en, sb_set_en;
  logic [4:0]  wr0_addr, wr1_addr, rd_a_addr, rd_b_addr, sb_set_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [31:0] a_data, b_data, a_data_nb, b_data_nb;
  logic        a_busy, b_busy, a_busy_nb, b_busy_nb;
  logic [31:0] bvec, bvec_nb;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  regfile_2w2r_sb #(.BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_a_addr(rd_a_addr), .rd_a_data(a_data), .rd_a_busy(a_busy),
    .rd_b_addr(rd_b_addr), .rd_b_data(b_data), .rd_b_busy(b_busy),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy_vec(bvec)
  );

  regfile_2w2r_sb #(.BYPASS(0), .ZERO_REG(0)) dut_nb (
    .clk(clk), .reset(reset),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_a_addr(rd_a_addr), .rd_a_data(a_data_nb), .rd_a_busy(a_busy_nb),
    .rd_b_addr(rd_b_addr), .rd_b_data(b_data_nb), .rd_b_busy(b_busy_nb),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy_vec(bvec_nb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0; sb_set_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    wr0_addr = 5'd0; wr1_addr = 5'd0; sb_set_addr = 5'd0;
    wr0_data = 32'h0; wr1_data = 32'h0;
    rd_a_addr = 5'd0; rd_b_addr = 5'd0;

    // Writes and sets during reset are ignored, outputs held at zero.
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
    sb_set_en = 1'b1; sb_set_addr = 5'd5; rd_a_addr = 5'd5;
    #2;
    chk("rst_rd_a", a_data, 32'h0);
    chk("rst_busy_a", {31'd0, a_busy}, 32'h0);
    chk("rst_bvec", bvec, 32'h0);
    tick();
    chk("rst_rd_a_nb", a_data_nb, 32'h0);
    chk("rst_bvec_nb", bvec_nb, 32'h0);
    idle();
    reset = 1'b1;
    #1;
    chk("post_rst_rd_a", a_data, 32'h0);
    chk("post_rst_bvec", bvec, 32'h0);

    // Write x5, mark x6 busy, then pulse reset between edges.
    tick();
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
    sb_set_en = 1'b1; sb_set_addr = 5'd6;
    tick();
    idle();
    chk("x5_written", a_data, 32'hDEADBEEF);
    chk("x6_busy", bvec, 32'h0000_0040);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_rd", a_data, 32'h0);
    chk("async_rst_bvec", bvec, 32'h0);
    chk("async_rst_rd_nb", a_data_nb, 32'h0);
    #1 reset = 1'b1;

    // Dual write collision on x7.
    tick();
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
    rd_a_addr = 5'd7;
    #1;
    chk("coll_byp_same", a_data, 32'h22);
    chk("coll_nb_same", a_data_nb, 32'h0);
    tick();
    idle();
    chk("coll_next", a_data, 32'h22);
    chk("coll_next_nb", a_data_nb, 32'h22);

    // Bypass on port B.
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hA5A5A5A5; rd_b_addr = 5'd3;
    #1;
    chk("byp_b_same", b_data, 32'hA5A5A5A5);
    chk("nobyp_b_same", b_data_nb, 32'h0);
    tick();
    idle();
    chk("byp_b_next", b_data, 32'hA5A5A5A5);
    chk("nobyp_b_next", b_data_nb, 32'hA5A5A5A5);

    // Register 0: hardwired in dut, ordinary in dut_nb.
    wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFFFFFF;
    sb_set_en = 1'b1; sb_set_addr = 5'd0; rd_a_addr = 5'd0;
    #1;
    chk("x0_rd_same", a_data, 32'h0);
    chk("x0_busy_same", {31'd0, a_busy}, 32'h0);
    tick();
    idle();
    chk("x0_rd", a_data, 32'h0);
    chk("x0_busy", {31'd0, a_busy}, 32'h0);
    chk("x0_bvec", bvec, 32'h0);
    chk("x0_rd_nb", a_data_nb, 32'hFFFFFFFF);
    chk("x0_bvec_nb", bvec_nb, 32'h1);
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'h0;
    tick();
    idle();
    chk("x0_clear_nb", bvec_nb, 32'h0);

    // Scoreboard lifecycle on x9.
    sb_set_en = 1'b1; sb_set_addr = 5'd9; rd_a_addr = 5'd9;
    tick();
    idle();
    chk("sb_set_x9", bvec, 32'h0000_0200);
    chk("sb_busy_a", {31'd0, a_busy}, 32'h1);
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h1234;
    #1;
    chk("sb_fwd_busy", {31'd0, a_busy}, 32'h0);
    chk("sb_nofwd_busy", {31'd0, a_busy_nb}, 32'h1);
    chk("sb_fwd_data", a_data, 32'h1234);
    tick();
    idle();
    chk("sb_clr_x9", bvec, 32'h0);
    chk("sb_clr_x9_nb", bvec_nb, 32'h0);
    chk("sb_x9_data", a_data_nb, 32'h1234);

    // Set/clear race on x4: set wins.
    sb_set_en = 1'b1; sb_set_addr = 5'd4;
    tick();
    idle();
    chk("race_pre", bvec, 32'h0000_0010);
    sb_set_en = 1'b1; sb_set_addr = 5'd4;
    wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h55; rd_b_addr = 5'd4;
    #1;
    chk("race_busy_same", {31'd0, b_busy}, 32'h1);
    chk("race_data_same", b_data, 32'h55);
    tick();
    idle();
    chk("race_data", b_data, 32'h55);
    chk("race_bvec", bvec, 32'h0000_0010);
    chk("race_bvec_nb", bvec_nb, 32'h0000_0010);

    // Clearing an idle register is harmless; distinct-address dual bypass.
    wr1_en = 1'b1; wr1_addr = 5'd10; wr1_data = 32'hBB;
    wr0_en = 1'b1; wr0_addr = 5'd11; wr0_data = 32'hAA;
    rd_a_addr = 5'd11; rd_b_addr = 5'd10;
    #1;
    chk("dual_a", a_data, 32'hAA);
    chk("dual_b", b_data, 32'hBB);
    tick();
    idle();
    chk("idle_clr_bvec", bvec, 32'h0000_0010);
    chk("dual_a_nb", a_data_nb, 32'hAA);
    chk("dual_b_nb", b_data_nb, 32'hBB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
